// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM states, count sizing
// and parameter legality.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width: $clog2 of the digit count, never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
      int unsigned n;
      if (digit == 0) return 1;
      n = width / digit;
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int unsigned width, input int unsigned digit);
      return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// DIGIT-wide ripple of full-subtractor cells; purely combinational.
module digit_subtractor #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             borrow_in_i,
   output logic [DIGIT-1:0] diff_o,
   output logic             borrow_out_o
);

   logic [DIGIT:0] w_bor;

   assign w_bor[0] = borrow_in_i;

   for (genvar g = 0; g < DIGIT; g++) begin : g_cell
      assign diff_o[g]    = a_i[g] ^ b_i[g] ^ w_bor[g];
      assign w_bor[g + 1] = (~a_i[g] & b_i[g]) | (~(a_i[g] ^ b_i[g]) & w_bor[g]);
   end

   assign borrow_out_o = w_bor[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, LSB digit first,
// valid/ready handshakes on both sides.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             borrow_in_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_out_o,
   output logic             overflow_o,
   output logic             zero_o
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

   if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
      $error("serial_subtractor: illegal WIDTH/DIGIT combination");
   end

   state_t            r_state, w_state_next;
   logic [WIDTH-1:0]  r_a, r_b, r_res;
   logic              r_borrow, r_amsb, r_bmsb;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_diff;
   logic              r_bout, r_ovf, r_zero;

   logic [DIGIT-1:0]  w_dig;
   logic              w_dig_bout;
   logic [WIDTH-1:0]  w_res_next;
   logic              w_accept, w_last, w_release;

   digit_subtractor #(.DIGIT(DIGIT)) u_digit (
      .a_i          (r_a[DIGIT-1:0]),
      .b_i          (r_b[DIGIT-1:0]),
      .borrow_in_i  (r_borrow),
      .diff_o       (w_dig),
      .borrow_out_o (w_dig_bout)
   );

   // Result digits enter from the MSB side so the final digit lands in place.
   assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dig) << (WIDTH - DIGIT));

   assign w_accept  = (r_state == IDLE) && in_valid_i;
   assign w_last    = (r_state == BUSY) && (r_cnt == CW'(N - 1));
   assign w_release = (r_state == DONE) && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) w_state_next = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a_i;
         r_b      <= b_i;
         r_borrow <= borrow_in_i;
         r_amsb   <= a_i[WIDTH-1];
         r_bmsb   <= b_i[WIDTH-1];
         r_cnt    <= '0;
      end else if (r_state == BUSY) begin
         r_a      <= r_a >> DIGIT;
         r_b      <= r_b >> DIGIT;
         r_res    <= w_res_next;
         r_borrow <= w_dig_bout;
         r_cnt    <= r_cnt + 1'b1;
         // Visible outputs update only on the edge that enters DONE.
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_dig_bout;
            r_ovf  <= (r_amsb != r_bmsb) && (w_res_next[WIDTH-1] != r_amsb);
            r_zero <= (w_res_next == '0);
         end
      end
   end

   assign diff_o       = r_diff;
   assign borrow_out_o = r_bout;
   assign overflow_o   = r_ovf;
   assign zero_o       = r_zero;

   logic w_unused;
   assign w_unused = w_release;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector table, multi-cycle corner sequences and a DIGIT sweep for
// the digit-serial subtractor.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid [4];
   logic       in_ready [4];
   logic [7:0] a [4];
   logic [7:0] b [4];
   logic       bin [4];
   logic       out_valid [4];
   logic       out_ready [4];
   logic [7:0] diff [4];
   logic       bout [4];
   logic       ovf [4];
   logic       zero [4];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Instance k has DIGIT = 1 << k; instance 1 (DIGIT=2) runs the directed tests.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
         .clk_i        (clk),
         .rst_n_i      (rst_n),
         .in_valid_i   (in_valid[g]),
         .in_ready_o   (in_ready[g]),
         .a_i          (a[g]),
         .b_i          (b[g]),
         .borrow_in_i  (bin[g]),
         .out_valid_o  (out_valid[g]),
         .out_ready_i  (out_ready[g]),
         .diff_o       (diff[g]),
         .borrow_out_o (bout[g]),
         .overflow_o   (ovf[g]),
         .zero_o       (zero[g])
      );
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
      logic       zero;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
      int guard = 0;
      while (!in_ready[k] && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("ready_before_accept", 32'(in_ready[k]), 32'd1);
      a[k] = av; b[k] = bv; bin[k] = bv_in; in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      a[k] = 8'hAA; b[k] = 8'h55; bin[k] = 1'b1;
   endtask

   task automatic wait_done(input int k, output int lat);
      lat = 1;
      while (!out_valid[k] && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      // lat counts edges after the accept edge until out_valid is seen
      lat = lat - 1;
      if (!out_valid[k]) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_out(input int k);
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask

   task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                         output logic [10:0] res, output int lat);
      start_op(k, av, bv, bv_in);
      wait_done(k, lat);
      res = {diff[k], bout[k], ovf[k], zero[k]};
      release_out(k);
   endtask

   function automatic logic [10:0] model(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
      logic [8:0] full;
      logic [7:0] d;
      full = {1'b0, av} - {1'b0, bv} - {8'd0, bv_in};
      d = full[7:0];
      return {d, full[8], (av[7] != bv[7]) && (d[7] != av[7]), d == 8'd0};
   endfunction

   initial begin
      logic [10:0] res;
      int lat;

      for (int k = 0; k < 4; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         a[k] = '0; b[k] = '0; bin[k] = 1'b0;
      end

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready[1]), 32'd1);
      check("reset_out_valid", 32'(out_valid[1]), 32'd0);
      check("reset_outputs", 32'({diff[1], bout[1], ovf[1], zero[1]}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(1, vecs[i].a, vecs[i].b, vecs[i].bin, res, lat);
         check($sformatf("vec%0d_result", i), 32'(res),
               32'({vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero}));
         check($sformatf("vec%0d_latency", i), lat, 32'd4);
      end

      // Backpressure: DONE holds while new operands are offered.
      start_op(1, 8'h05, 8'h03, 1'b0);
      wait_done(1, lat);
      a[1] = 8'h40; b[1] = 8'h01; bin[1] = 1'b0; in_valid[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d_hold", c),
               32'({out_valid[1], in_ready[1], diff[1], bout[1], ovf[1], zero[1]}),
               32'({1'b1, 1'b0, 8'h02, 3'b000}));
      end
      in_valid[1] = 1'b0;
      release_out(1);
      check("bp_release_idle", 32'({out_valid[1], in_ready[1]}), 32'b01);
      @(posedge clk); #1;
      check("bp_no_accept", 32'({out_valid[1], in_ready[1]}), 32'b01);

      // Asynchronous reset two cycles into BUSY.
      start_op(1, 8'hFF, 8'h01, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy_ready", 32'(in_ready[1]), 32'd1);
      check("rst_mid_busy_outs", 32'({out_valid[1], diff[1], bout[1], ovf[1], zero[1]}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(1, 8'h10, 8'h01, 1'b0, res, lat);
      check("post_reset_result", 32'(res), 32'({8'h0F, 3'b000}));
      check("post_reset_latency", lat, 32'd4);

      // DIGIT sweep against the reference model.
      for (int k = 0; k < 4; k++) begin
         int fails_before = n_fail;
         for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic rbin;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            run_op(k, ra, rb, rbin, res, lat);
            check($sformatf("sweep_d%0d_%0d_result a=%0h b=%0h bin=%0d", 1 << k, i, ra, rb, rbin),
                  32'(res), 32'(model(ra, rb, rbin)));
            check($sformatf("sweep_d%0d_%0d_latency", 1 << k, i), lat, 32'(8 >> k));
            if (n_fail - fails_before > 20) break;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
